// File: rtl/core_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_pkg : shared RV32I opcodes, ALU encoding and control bundle |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package core_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] JMP_NONE = 2'd0;
  localparam logic [1:0] JMP_JAL  = 2'd1;
  localparam logic [1:0] JMP_JALR = 2'd2;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // alu_s1: 0=rs1, 1=pc; alu_s2: 0=rs2, 1=imm; branch_ctrl = {is_branch, funct3}
  typedef struct packed {
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] wb_ctrl;
    alu_op_e    alu_op;
    logic       alu_s1;
    logic       alu_s2;
    logic [3:0] branch_ctrl;
    logic [2:0] mem_ctrl;
    logic [1:0] jump_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_wr:      1'b0,
    mem_rd:      1'b0,
    mem_wr:      1'b0,
    wb_ctrl:     WB_ALU,
    alu_op:      ALU_ADD,
    alu_s1:      1'b0,
    alu_s2:      1'b0,
    branch_ctrl: 4'd0,
    mem_ctrl:    3'd0,
    jump_ctrl:   JMP_NONE
  };

  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
    alu_decode = ALU_ADD;
    case (funct3)
      3'b000:  alu_decode = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_bypass.sv
`default_nettype none
// +------------------------------------------------------------------+
// | regfile_bypass : 2R/1W register file, x0 hardwired, opt. bypass  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module regfile_bypass #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] regs [NREGS];
  logic            rs1_fwd;
  logic            rs2_fwd;

  always_ff @(posedge clk) begin
    if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      assign rs1_fwd = wb_en && (wb_addr == rs1_addr);
      assign rs2_fwd = wb_en && (wb_addr == rs2_addr);
    end else begin : g_no_bypass
      assign rs1_fwd = 1'b0;
      assign rs2_fwd = 1'b0;
    end
  endgenerate

  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
    if (rs1_addr == '0)  rs1_data = '0;
    else if (rs1_fwd)    rs1_data = wb_data;
    if (rs2_addr == '0)  rs2_data = '0;
    else if (rs2_fwd)    rs2_data = wb_data;
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_stage_pipe : RV32I decode stage with ID/EX pipeline register  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module id_stage_pipe
  import core_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_pc4,
  input  logic [31:0]     if_inst,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_pc4,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [AW-1:0]   ex_rs1,
  output logic [AW-1:0]   ex_rs2,
  output logic [AW-1:0]   ex_rd,
  output ctrl_t           ex_ctrl
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            use_rs1;
  logic            use_rs2;
  logic            use_rd;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  ctrl_t           ctrl;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            hold;
  logic            lu_haz;

  assign opcode = if_inst[6:0];
  assign funct3 = if_inst[14:12];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    imm32   = '0;
    ctrl    = CTRL_NOP;
    case (opcode)
      OP_LUI: begin
        use_rd = 1'b1;  ctrl.reg_wr = 1'b1;  ctrl.alu_op = ALU_PASSB;  ctrl.alu_s2 = 1'b1;
        imm32  = {if_inst[31:12], 12'b0};
      end
      OP_AUIPC: begin
        use_rd = 1'b1;  ctrl.reg_wr = 1'b1;  ctrl.alu_s1 = 1'b1;  ctrl.alu_s2 = 1'b1;
        imm32  = {if_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        use_rd = 1'b1;  ctrl.reg_wr = 1'b1;  ctrl.wb_ctrl = WB_PC4;  ctrl.jump_ctrl = JMP_JAL;
        ctrl.alu_s1 = 1'b1;  ctrl.alu_s2 = 1'b1;
        imm32  = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
      end
      OP_JALR: begin
        use_rd = 1'b1;  use_rs1 = 1'b1;  ctrl.reg_wr = 1'b1;  ctrl.wb_ctrl = WB_PC4;
        ctrl.jump_ctrl = JMP_JALR;  ctrl.alu_s2 = 1'b1;
        imm32  = {{20{if_inst[31]}}, if_inst[31:20]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1;  use_rs2 = 1'b1;  ctrl.branch_ctrl = {1'b1, funct3};  ctrl.alu_op = ALU_SUB;
        imm32   = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
      end
      OP_LOAD: begin
        use_rd = 1'b1;  use_rs1 = 1'b1;  ctrl.reg_wr = 1'b1;  ctrl.mem_rd = 1'b1;
        ctrl.wb_ctrl = WB_MEM;  ctrl.mem_ctrl = funct3;  ctrl.alu_s2 = 1'b1;
        imm32  = {{20{if_inst[31]}}, if_inst[31:20]};
      end
      OP_STORE: begin
        use_rs1 = 1'b1;  use_rs2 = 1'b1;  ctrl.mem_wr = 1'b1;  ctrl.mem_ctrl = funct3;  ctrl.alu_s2 = 1'b1;
        imm32   = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
      end
      OP_IMM: begin
        // bit 30 selects SRAI only for shifts; for other I-ops it is immediate data
        use_rd = 1'b1;  use_rs1 = 1'b1;  ctrl.reg_wr = 1'b1;  ctrl.alu_s2 = 1'b1;
        ctrl.alu_op = alu_decode(funct3, (funct3 == 3'b101) && if_inst[30]);
        imm32  = {{20{if_inst[31]}}, if_inst[31:20]};
      end
      OP_REG: begin
        use_rd = 1'b1;  use_rs1 = 1'b1;  use_rs2 = 1'b1;  ctrl.reg_wr = 1'b1;
        ctrl.alu_op = alu_decode(funct3, if_inst[30]);
      end
      default: ;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

  // Unused fields are zeroed so hazard and EX forwarding never match on immediate bits
  assign rs1 = use_rs1 ? AW'(if_inst[19:15]) : '0;
  assign rs2 = use_rs2 ? AW'(if_inst[24:20]) : '0;
  assign rd  = use_rd  ? AW'(if_inst[11:7])  : '0;

  regfile_bypass #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_regfile (
    .clk      (clk),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  assign hold     = ex_valid && !ex_ready;
  assign lu_haz   = ex_valid && ex_ctrl.mem_rd && (ex_rd != '0) && ((ex_rd == rs1) || (ex_rd == rs2));
  assign id_ready = !hold && !lu_haz && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_pc4     <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= CTRL_NOP;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
    end else if (hold) begin
      ex_valid <= ex_valid;
    end else if (lu_haz) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
    end else if (if_valid) begin
      ex_valid   <= 1'b1;
      ex_pc      <= if_pc;
      ex_pc4     <= if_pc4;
      ex_rs1_val <= rs1_val;
      ex_rs2_val <= rs2_val;
      ex_imm     <= imm;
      ex_rs1     <= rs1;
      ex_rs2     <= rs2;
      ex_rd      <= rd;
      ex_ctrl    <= ctrl;
    end else begin
      ex_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
